// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter between a processor port and a debug/loader port.
// Each access runs IDLE->ACCESS->WAIT->DONE; CPU is preferred, but the debug port is not starved.
module arbitro_memoria_dados #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 16,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_CPU_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                owner_r;      // 1'b1 = debug port owns the transaction
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STREAK_W-1:0] streak_r;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic [DATA_W-1:0]   dbg_rdata_r;
  logic                start_s;
  logic                dbg_wins_s;

  // Debug wins when it is alone or when the CPU has used up its streak while debug waited.
  assign dbg_wins_s = dbg_req && (!cpu_req || (streak_r == STREAK_W'(MAX_CPU_STREAK)));
  assign start_s    = (state_r == IDLE) && (cpu_req || dbg_req);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = WAIT;
      WAIT:    state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Latch the winning request and track how long the debug port has been passed over
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r  <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      streak_r <= '0;
    end else if (start_s) begin
      owner_r <= dbg_wins_s;
      if (dbg_wins_s) begin
        we_r    <= dbg_we;
        addr_r  <= dbg_addr;
        wdata_r <= dbg_wdata;
      end else begin
        we_r    <= cpu_we;
        addr_r  <= cpu_addr;
        wdata_r <= cpu_wdata;
      end
      if (dbg_wins_s || !dbg_req) begin
        streak_r <= '0;
      end else begin
        streak_r <= streak_r + STREAK_W'(1);
      end
    end else begin
      owner_r  <= owner_r;
      we_r     <= we_r;
      addr_r   <= addr_r;
      wdata_r  <= wdata_r;
      streak_r <= streak_r;
    end
  end

  // Capture RAM read data for the owner at the end of WAIT
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rdata_r <= '0;
      dbg_rdata_r <= '0;
    end else if ((state_r == WAIT) && !we_r) begin
      if (owner_r) begin
        dbg_rdata_r <= mem_q;
      end else begin
        cpu_rdata_r <= mem_q;
      end
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
      dbg_rdata_r <= dbg_rdata_r;
    end
  end

  // Output decode from the state register; the write strobe is also gated by reset
  always_comb begin
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    cpu_ack  = 1'b0;
    dbg_ack  = 1'b0;
    mem_wren = 1'b0;
    busy     = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      ACCESS: begin
        busy     = 1'b1;
        cpu_gnt  = !owner_r;
        dbg_gnt  = owner_r;
        mem_wren = we_r && !reset;
      end
      WAIT: begin
        busy    = 1'b1;
        cpu_gnt = !owner_r;
        dbg_gnt = owner_r;
      end
      DONE: begin
        busy    = 1'b1;
        cpu_gnt = !owner_r;
        dbg_gnt = owner_r;
        cpu_ack = !owner_r;
        dbg_ack = owner_r;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign mem_address = addr_r;
  assign mem_data    = wdata_r;
  assign cpu_rdata   = cpu_rdata_r;
  assign dbg_rdata   = dbg_rdata_r;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Self-checking bench for arbitro_memoria_dados: synchronous RAM model plus a
// transaction-level reference (memory array, per-port read values, CPU streak count).
module tb_arbitro_memoria_dados;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int MAX_CPU_STREAK = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic              cpu_ack, cpu_gnt, dbg_ack, dbg_gnt;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              busy;
  logic              ram_clear;

  logic [DATA_W-1:0] ram [64];

  int                checks = 0;
  int                failures = 0;
  logic [DATA_W-1:0] ref_mem [64];
  logic [DATA_W-1:0] exp_cpu_rdata;
  logic [DATA_W-1:0] exp_dbg_rdata;
  int                model_streak;
  logic [ADDR_W-1:0] last_addr;

  always #5 clock = ~clock;

  arbitro_memoria_dados #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_STREAK(MAX_CPU_STREAK)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  // Synchronous RAM: read data appears one cycle after the address is sampled
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else begin
      if (mem_wren) ram[mem_address] <= mem_data;
    end
    mem_q <= ram[mem_address];
  end

  task automatic cycle();
    @(negedge clock);
  endtask

  task automatic scramble_idle_port(input bit is_dbg);
    if (is_dbg) begin
      cpu_req = 1'b0; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 6'($urandom); cpu_wdata = 16'($urandom);
    end else begin
      dbg_req = 1'b0; dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = 6'($urandom); dbg_wdata = 16'($urandom);
    end
  endtask

  // One transaction on a single port; called at a negedge with the arbiter idle.
  task automatic do_txn(input bit is_dbg, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata);
    logic gnt_own, gnt_oth, ack_own, ack_oth;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    scramble_idle_port(is_dbg);
    model_streak = 0;
    cycle();
    gnt_own = is_dbg ? dbg_gnt : cpu_gnt;
    gnt_oth = is_dbg ? cpu_gnt : dbg_gnt;
    checks++; if (gnt_own !== 1'b1 || gnt_oth !== 1'b0) begin failures++;
      $display("FAIL access_gnt: own=%0b other=%0b required 1/0", gnt_own, gnt_oth); end
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL access_busy: got %0b required 1", busy); end
    checks++; if (mem_wren !== we) begin failures++;
      $display("FAIL access_wren: got %0b required %0b", mem_wren, we); end
    checks++; if (mem_address !== addr || mem_data !== wdata) begin failures++;
      $display("FAIL access_bus: addr=%h data=%h required %h/%h", mem_address, mem_data, addr, wdata); end
    scramble_idle_port(is_dbg);
    cycle();
    ack_own = is_dbg ? dbg_ack : cpu_ack;
    checks++; if (mem_wren !== 1'b0 || ack_own !== 1'b0) begin failures++;
      $display("FAIL wait_state: wren=%0b ack=%0b required 0/0", mem_wren, ack_own); end
    scramble_idle_port(is_dbg);
    cycle();
    ack_own = is_dbg ? dbg_ack : cpu_ack;
    ack_oth = is_dbg ? cpu_ack : dbg_ack;
    if (we) ref_mem[addr] = wdata;
    else if (is_dbg) exp_dbg_rdata = ref_mem[addr];
    else exp_cpu_rdata = ref_mem[addr];
    checks++; if (ack_own !== 1'b1 || ack_oth !== 1'b0) begin failures++;
      $display("FAIL done_ack: own=%0b other=%0b required 1/0", ack_own, ack_oth); end
    checks++; if (cpu_rdata !== exp_cpu_rdata || dbg_rdata !== exp_dbg_rdata) begin failures++;
      $display("FAIL done_rdata: cpu=%h dbg=%h required %h/%h", cpu_rdata, dbg_rdata,
               exp_cpu_rdata, exp_dbg_rdata); end
    cpu_req = 1'b0; dbg_req = 1'b0;
    cycle();
    checks++; if (busy !== 1'b0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || cpu_ack !== 1'b0
                  || dbg_ack !== 1'b0) begin failures++;
      $display("FAIL back_idle: busy=%0b gnt=%0b%0b ack=%0b%0b required all 0",
               busy, cpu_gnt, dbg_gnt, cpu_ack, dbg_ack); end
    last_addr = addr;
  endtask

  task automatic test_reset();
    reset = 1'b1; ram_clear = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h2A; cpu_wdata = 16'hA5A5;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'h15; dbg_wdata = 16'h5A5A;
    cycle(); cycle();
    checks++; if (busy !== 1'b0 || mem_wren !== 1'b0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0
                  || cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin failures++;
      $display("FAIL reset_ctrl: busy=%0b wren=%0b gnt=%0b%0b ack=%0b%0b required all 0",
               busy, mem_wren, cpu_gnt, dbg_gnt, cpu_ack, dbg_ack); end
    checks++; if (mem_address !== 6'h00 || mem_data !== 16'h0000) begin failures++;
      $display("FAIL reset_bus: addr=%h data=%h required 0/0", mem_address, mem_data); end
    checks++; if (cpu_rdata !== 16'h0000 || dbg_rdata !== 16'h0000) begin failures++;
      $display("FAIL reset_rdata: cpu=%h dbg=%h required 0/0", cpu_rdata, dbg_rdata); end
    cpu_req = 1'b0; dbg_req = 1'b0; reset = 1'b0; ram_clear = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    exp_cpu_rdata = '0; exp_dbg_rdata = '0; model_streak = 0; last_addr = '0;
    cycle();
  endtask

  task automatic test_cpu_write_read();
    do_txn(1'b0, 1'b1, 6'h0A, 16'h1234);
    do_txn(1'b0, 1'b0, 6'h0A, 16'h0000);
    checks++; if (cpu_rdata !== 16'h1234 || dbg_rdata !== 16'h0000) begin failures++;
      $display("FAIL cpu_readback: cpu=%h dbg=%h required 1234/0000", cpu_rdata, dbg_rdata); end
  endtask

  task automatic test_dbg_write();
    do_txn(1'b1, 1'b1, 6'h3F, 16'hFFFF);
    do_txn(1'b1, 1'b0, 6'h3F, 16'h0000);
    checks++; if (dbg_rdata !== 16'hFFFF || cpu_rdata !== 16'h1234) begin failures++;
      $display("FAIL dbg_readback: dbg=%h cpu=%h required FFFF/1234", dbg_rdata, cpu_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 15)), 16'($urandom));
    end
  endtask

  // Both ports request continuously; the model picks owners from the streak rule.
  task automatic test_back_to_back();
    bit own_dbg;
    int dbg_count = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h0A;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'h3F;
    for (int t = 0; t < 10; t++) begin
      if (model_streak == MAX_CPU_STREAK) begin own_dbg = 1'b1; model_streak = 0; end
      else begin own_dbg = 1'b0; model_streak++; end
      if (own_dbg) dbg_count++;
      cycle();
      checks++; if (dbg_gnt !== own_dbg || cpu_gnt !== !own_dbg) begin failures++;
        $display("FAIL b2b_owner[%0d]: gnt cpu=%0b dbg=%0b required dbg=%0b", t, cpu_gnt,
                 dbg_gnt, own_dbg); end
      cycle(); cycle();
      if (own_dbg) exp_dbg_rdata = ref_mem[6'h3F];
      else exp_cpu_rdata = ref_mem[6'h0A];
      checks++; if (dbg_ack !== own_dbg || cpu_ack !== !own_dbg) begin failures++;
        $display("FAIL b2b_ack[%0d]: ack cpu=%0b dbg=%0b required dbg=%0b", t, cpu_ack,
                 dbg_ack, own_dbg); end
      checks++; if (cpu_rdata !== exp_cpu_rdata || dbg_rdata !== exp_dbg_rdata) begin failures++;
        $display("FAIL b2b_rdata[%0d]: cpu=%h dbg=%h required %h/%h", t, cpu_rdata, dbg_rdata,
                 exp_cpu_rdata, exp_dbg_rdata); end
      cycle();
      checks++; if (busy !== 1'b0) begin failures++;
        $display("FAIL b2b_idle[%0d]: busy=%0b required 0", t, busy); end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    model_streak = 0;
    last_addr = 6'h3F;
    checks++; if (dbg_count !== 2) begin failures++;
      $display("FAIL b2b_dbg_count: got %0d required 2", dbg_count); end
    cycle();
  endtask

  task automatic test_reset_mid_write();
    do_txn(1'b0, 1'b1, 6'h05, 16'h1111);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h05; cpu_wdata = 16'hBEEF;
    cycle();
    checks++; if (mem_wren !== 1'b1) begin failures++;
      $display("FAIL abort_pre_wren: got %0b required 1", mem_wren); end
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    checks++; if (mem_wren !== 1'b0) begin failures++;
      $display("FAIL abort_wren_gated: got %0b required 0", mem_wren); end
    cycle();
    reset = 1'b0;
    exp_cpu_rdata = '0; exp_dbg_rdata = '0; model_streak = 0;
    checks++; if (busy !== 1'b0 || cpu_rdata !== 16'h0000 || dbg_rdata !== 16'h0000
                  || mem_address !== 6'h00) begin failures++;
      $display("FAIL abort_state: busy=%0b rdata=%h/%h addr=%h required 0", busy, cpu_rdata,
               dbg_rdata, mem_address); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (cpu_ack !== 1'b0) begin failures++;
        $display("FAIL abort_no_ack[%0d]: got %0b required 0", i, cpu_ack); end
    end
    do_txn(1'b0, 1'b0, 6'h05, 16'h0000);
    checks++; if (cpu_rdata !== 16'h1111) begin failures++;
      $display("FAIL abort_prior_value: got %h required 1111", cpu_rdata); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (busy !== 1'b0 || mem_wren !== 1'b0 || cpu_ack !== 1'b0 || dbg_ack !== 1'b0
                    || mem_address !== last_addr) begin failures++;
        $display("FAIL idle[%0d]: busy=%0b wren=%0b ack=%0b%0b addr=%h required 0/0/00/%h", i,
                 busy, mem_wren, cpu_ack, dbg_ack, mem_address, last_addr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cpu_write_read();
    test_dbg_write();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
